// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// The block sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), to the device.
// It holds CLK low to inhibit the bus, then pulls DAT low to request to send. The device
// then generates the clocks, and on each of them the block shifts out 8 data bits, odd
// parity and stop. Finally it samples the device ACK.
// Both lines are open-drain: an *_oe output of 1 pulls the pin low.
// Ports:
//   i_clk, i_rst_n              sampling clock, async active-low reset
//   i_valid, i_data, o_ready    command handshake (accepted on i_valid && o_ready)
//   o_busy                      high whenever a transfer is in flight
//   i_ps2_clk, i_ps2_dat        raw pin levels (asynchronous)
//   o_ps2_clk_oe, o_ps2_dat_oe  pin pull-down enables
//   o_done, o_ack_ok, o_error   one-cycle transfer result
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_busy,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_dat_oe,
  output logic       o_done,
  output logic       o_ack_ok,
  output logic       o_error
);

  localparam int CW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [3:0]    bit_idx;
  logic [9:0]    frame;
  logic [1:0]    clk_s, dat_s;
  logic          clk_d;
  logic          fall;

  // Two-flop synchronizers; reset to the idle-high bus level so that
  // reset release never produces a spurious falling edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_d <= 1'b1;
    end else begin
      clk_s <= {clk_s[0], i_ps2_clk};
      dat_s <= {dat_s[0], i_ps2_dat};
      clk_d <= clk_s[1];
    end
  end

  assign fall = clk_d & ~clk_s[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      tcnt         <= '0;
      bit_idx      <= '0;
      frame        <= '0;
      o_ps2_clk_oe <= 1'b0;
      o_ps2_dat_oe <= 1'b0;
      o_done       <= 1'b0;
      o_ack_ok     <= 1'b0;
      o_error      <= 1'b0;
      o_ready      <= 1'b1;
      o_busy       <= 1'b0;
    end else begin
      o_done   <= 1'b0;
      o_ack_ok <= 1'b0;
      o_error  <= 1'b0;
      case (state)
        IDLE: begin
          // The o_done cycle is spent here with o_ready still low, so
          // o_ready reasserts one cycle after o_done.
          o_ps2_clk_oe <= 1'b0;
          o_ps2_dat_oe <= 1'b0;
          o_ready      <= 1'b1;
          o_busy       <= 1'b0;
          if (i_valid && o_ready) begin
            frame        <= {1'b1, ~^i_data, i_data};
            cnt          <= '0;
            o_ps2_clk_oe <= 1'b1;
            o_ready      <= 1'b0;
            o_busy       <= 1'b1;
            state        <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
            o_ps2_dat_oe <= 1'b1;  // start bit; CLK still held for the REQ cycle
            state        <= REQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REQ: begin
          o_ps2_clk_oe <= 1'b0;    // hand the clock to the device
          tcnt         <= '0;
          bit_idx      <= '0;
          state        <= SEND;
        end
        SEND: begin
          if (fall) begin
            // Present the next bit while the device clock is low.
            // It is sampled on the following rise.
            tcnt         <= '0;
            o_ps2_dat_oe <= ~frame[bit_idx];
            bit_idx      <= bit_idx + 1'b1;
            if (bit_idx == 4'd9) state <= ACK;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            o_ps2_clk_oe <= 1'b0;
            o_ps2_dat_oe <= 1'b0;
            o_done       <= 1'b1;
            o_error      <= 1'b1;
            state        <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ACK: begin
          o_ps2_dat_oe <= 1'b0;
          if (fall) begin
            o_done   <= 1'b1;
            o_ack_ok <= ~dat_s[1];
            o_error  <= dat_s[1];
            state    <= IDLE;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            o_ps2_clk_oe <= 1'b0;
            o_done       <= 1'b1;
            o_error      <= 1'b1;
            state        <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx.
// A PS/2 device model provides the clocks, captures the bits on the wire and answers with
// ACK, NACK, silence or an aborted transfer. Each command issued pushes the expected
// outcome into a scoreboard. A monitor pops one entry on each o_done and compares the
// result flags and the captured wire frame.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, busy, clk_oe, dat_oe, done, ack_ok, error;
  logic       dev_clk_hi = 1'b1;
  logic       dev_dat_lo = 1'b0;
  logic       ps2_clk, ps2_dat;

  assign ps2_clk = ~clk_oe & dev_clk_hi;
  assign ps2_dat = ~dat_oe & ~dev_dat_lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] b;
    logic       ack;
    logic       err;
    logic       has_frame;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] wire_q[$];
  exp_t       mon_e;
  logic [9:0] cap;
  int         dev_mode = 0;   // 0 ack, 1 nack, 2 silent, 3 abort after 4 clocks
  int         dev_falls = 0;

  ps2_host_tx dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
    .o_ready(ready), .o_busy(busy),
    .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat),
    .o_ps2_clk_oe(clk_oe), .o_ps2_dat_oe(dat_oe),
    .o_done(done), .o_ack_ok(ack_ok), .o_error(error)
  );

  always #5 clk = ~clk;

  // Odd parity: parity bit makes the total count of ones odd.
  function automatic logic odd_par(input logic [7:0] b);
    return ($countones(b) % 2 == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Device model
  initial begin
    forever begin
      @(negedge clk);
      if (clk_oe && dat_oe) begin
        dev_falls = 0;
        while (clk_oe) @(negedge clk);
        repeat (4) @(negedge clk);
        if (dev_mode != 2) begin
          for (int i = 0; i < 11; i++) begin
            if (dev_mode == 3 && i == 4) break;
            dev_clk_hi = 1'b0;
            dev_falls++;
            repeat (6) @(negedge clk);
            dev_clk_hi = 1'b1;
            if (i < 10) cap[i] = ps2_dat;
            if (i == 9) begin
              wire_q.push_back(cap);
              if (dev_mode == 0) dev_dat_lo = 1'b1;
            end
            repeat (6) @(negedge clk);
          end
          dev_dat_lo = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no transfer pending");
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_ok", ack_ok, mon_e.ack);
          chk("error", error, mon_e.err);
          if (mon_e.has_frame) begin
            if (wire_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL wire_frame: got none expected byte %0h", mon_e.b);
            end else begin
              chk("wire_frame", wire_q.pop_front(), {1'b1, odd_par(mon_e.b), mon_e.b});
            end
          end
        end
      end else if (ack_ok || error) begin
        checks++; errors++;
        $display("FAIL flags_outside_done: got ack_ok=%0b error=%0b expected 0", ack_ok, error);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 6000) begin @(negedge clk); n++; end
    chk("ready_wait", ready, 1'b1);
  endtask

  task automatic issue(input logic [7:0] b, input int mode, input bit hold_aa);
    int n;
    wait_ready();
    dev_mode = mode;
    valid = 1'b1;
    data = b;
    if (mode != 3) exp_q.push_back('{b, (mode == 0), (mode != 0), (mode != 2)});
    @(negedge clk);
    if (hold_aa) data = 8'hAA; else valid = 1'b0;
    n = 0;
    while (clk_oe && !dat_oe && n < 100) begin n++; @(negedge clk); end
    chk("inhibit_len", n, 12);
    n = 0;
    while (clk_oe && dat_oe && n < 100) begin n++; @(negedge clk); end
    chk("req_len", n, 1);
  endtask

  initial begin
    int k;
    logic [7:0] rb;
    repeat (3) @(negedge clk);
    chk("reset_state", {ready, busy, clk_oe, dat_oe, done, ack_ok, error}, 7'b1000000);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'hED, 0, 1'b0); wait_ready();
    issue(8'h01, 0, 1'b0); wait_ready();
    issue(8'hFF, 0, 1'b0); wait_ready();

    // No ACK from the device
    issue(8'h3C, 1, 1'b0); wait_ready();
    @(negedge clk);
    chk("idle_after_nack", {ready, busy}, 2'b10);

    // Silent device: timeout
    issue(8'h5A, 2, 1'b0);
    k = 0;
    while (!done && k < 3000) begin k++; @(negedge clk); end
    chk("timeout_cycles", k, 2000);
    chk("timeout_release", {clk_oe, dat_oe}, 2'b00);
    wait_ready();

    // 0xAA held on i_valid while 0xF4 is in flight
    issue(8'hF4, 0, 1'b1);
    exp_q.push_back('{8'hAA, 1'b1, 1'b0, 1'b1});
    k = 0;
    while (!ready && k < 6000) begin k++; @(negedge clk); end
    @(negedge clk);
    chk("aa_accept", {ready, busy, clk_oe}, 3'b011);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    wait_ready();

    // Reset mid-SEND after edge 4
    issue(8'hED, 3, 1'b0);
    k = 0;
    while (dev_falls < 4 && k < 500) begin k++; @(negedge clk); end
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_send", {clk_oe, dat_oe, done, ready, busy}, 5'b00010);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(8'hED, 0, 1'b0); wait_ready();

    // Randomized bytes with random ACK/NACK
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      issue(rb, int'($urandom_range(0, 1)), 1'b0);
      wait_ready();
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

endmodule
